// File: rtl/komandara_k10_pkg.sv
// Shared types for the K10 load/store unit: access sizes and FSM states.
package komandara_k10_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/k10_lsu_align.sv
// Combinational data path for the LSU: byte enables, store lane replication,
// misalignment detection and load lane select with sign/zero extension.
module k10_lsu_align
  import komandara_k10_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  lsu_size_e   ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    misaligned_o = 1'b0;
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    case (size_i)
      LSU_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      LSU_HALF: begin
        misaligned_o = addr_lo_i[0];
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{wdata_i[15:0]}};
      end
      LSU_WORD: begin
        misaligned_o = (addr_lo_i != 2'b00);
        be_o         = 4'b1111;
      end
      default: misaligned_o = 1'b1; // 2'b11 is an illegal size
    endcase
  end

  always_comb begin
    shifted   = rdata_i >> {ld_addr_lo_i, 3'b000};
    ld_data_o = rdata_i;
    case (ld_size_i)
      LSU_BYTE: ld_data_o = {{24{~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
      LSU_HALF: ld_data_o = {{16{~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
      default:  ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/k10_lsu.sv
// K10 load/store unit: single-outstanding OBI-style data port driven by a
// four-state FSM, with optional grant timeout that aborts with a bus error.
module k10_lsu
  import komandara_k10_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_data_req,
  output logic [31:0] o_data_addr,
  output logic        o_data_we,
  output logic [3:0]  o_data_be,
  output logic [31:0] o_data_wdata,
  input  logic        i_data_gnt,
  input  logic        i_data_rvalid,
  input  logic [31:0] i_data_rdata,
  input  logic        i_data_err,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  output logic        o_err_misaligned,
  output logic        o_err_bus
);

  localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  lsu_size_e   size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_mis_q, err_mis_d;
  logic        err_bus_q, err_bus_d;
  logic [31:0] cnt_q, cnt_d;

  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ld_data;

  k10_lsu_align u_align (
    .size_i        (lsu_size_e'(i_size)),
    .addr_lo_i     (i_addr[1:0]),
    .wdata_i       (i_wdata),
    .misaligned_o  (misaligned),
    .be_o          (be_new),
    .wdata_o       (wdata_new),
    .ld_size_i     (size_q),
    .ld_addr_lo_i  (addr_lo_q),
    .ld_unsigned_i (uns_q),
    .rdata_i       (i_data_rdata),
    .ld_data_o     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_lo_d   = addr_lo_q;
    data_addr_d = data_addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_mis_d   = err_mis_q;
    err_bus_d   = err_bus_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          we_d        = i_we;
          size_d      = lsu_size_e'(i_size);
          uns_d       = i_unsigned;
          addr_lo_d   = i_addr[1:0];
          data_addr_d = {i_addr[31:2], 2'b00};
          be_d        = be_new;
          wdata_d     = wdata_new;
          rdata_d     = 32'h0;
          err_mis_d   = misaligned;
          err_bus_d   = 1'b0;
          cnt_d       = 32'h0;
          state_d     = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        if (i_data_gnt) begin
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if ((TimeoutLimit != 32'd0) && (cnt_q + 32'd1 == TimeoutLimit)) begin
            state_d   = DONE;
            err_bus_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (i_data_rvalid) begin
          state_d   = DONE;
          err_bus_d = i_data_err;
          rdata_d   = (we_q || i_data_err) ? 32'h0 : ld_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= LSU_BYTE;
      uns_q       <= 1'b0;
      addr_lo_q   <= 2'b00;
      data_addr_q <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      err_mis_q   <= 1'b0;
      err_bus_q   <= 1'b0;
      cnt_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_lo_q   <= addr_lo_d;
      data_addr_q <= data_addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_mis_q   <= err_mis_d;
      err_bus_q   <= err_bus_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_busy           = (state_q != IDLE);
  assign o_data_req       = (state_q == REQ);
  assign o_data_addr      = data_addr_q;
  assign o_data_we        = we_q;
  assign o_data_be        = be_q;
  assign o_data_wdata     = wdata_q;
  assign o_valid          = (state_q == DONE);
  assign o_rdata          = rdata_q;
  assign o_err_misaligned = err_mis_q;
  assign o_err_bus        = err_bus_q;

endmodule

// File: tb/tb_k10_lsu.sv
// Scoreboard bench for k10_lsu: directed ops push expected completions, a
// negedge monitor pops and compares them whenever o_valid is seen.
module tb_k10_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, data_req, data_we;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        gnt, rvalid, derr;
  logic [31:0] rdata_in;
  logic        ovalid, err_mis, err_bus;
  logic [31:0] ordata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        bus;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  k10_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_valid          (valid),
    .i_we             (we),
    .i_size           (size),
    .i_unsigned       (uns),
    .i_addr           (addr),
    .i_wdata          (wdata),
    .o_busy           (busy),
    .o_data_req       (data_req),
    .o_data_addr      (data_addr),
    .o_data_we        (data_we),
    .o_data_be        (data_be),
    .o_data_wdata     (data_wdata),
    .i_data_gnt       (gnt),
    .i_data_rvalid    (rvalid),
    .i_data_rdata     (rdata_in),
    .i_data_err       (derr),
    .o_valid          (ovalid),
    .o_rdata          (ordata),
    .o_err_misaligned (err_mis),
    .o_err_bus        (err_bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ovalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_o_valid: got o_valid=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("o_rdata", ordata, e.rdata);
        check("o_err_misaligned", 32'(err_mis), 32'(e.mis));
        check("o_err_bus", 32'(err_bus), 32'(e.bus));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gnt_dly < 0 means the grant never comes (timeout path).
  task automatic do_op(input string nm, input logic op_we, input logic [1:0] op_size,
                       input logic op_uns, input logic [31:0] op_addr,
                       input logic [31:0] op_wdata, input int gnt_dly,
                       input logic [31:0] mem_rdata, input logic mem_err,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input logic exp_mis, input logic exp_bus);
    exp_t e;
    int n;
    e.rdata = exp_rd;
    e.mis   = exp_mis;
    e.bus   = exp_bus;
    exp_q.push_back(e);
    valid = 1'b1;
    we    = op_we;
    size  = op_size;
    uns   = op_uns;
    addr  = op_addr;
    wdata = op_wdata;
    tick();
    valid = 1'b0;
    if (exp_mis) begin
      for (int i = 0; i < 3; i++) begin
        check({nm, " no_req"}, 32'(data_req), 32'd0);
        tick();
      end
    end else if (gnt_dly < 0) begin
      n = 0;
      while (data_req === 1'b1 && n < 20) begin
        n++;
        tick();
      end
      check({nm, " req_cycles"}, 32'(n), 32'd4);
      check({nm, " o_valid"}, 32'(ovalid), 32'd1);
      tick();
      check({nm, " busy_after"}, 32'(busy), 32'd0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        if (i == gnt_dly) gnt = 1'b1;
        check({nm, " req"}, 32'(data_req), 32'd1);
        check({nm, " addr"}, data_addr, {op_addr[31:2], 2'b00});
        check({nm, " be"}, 32'(data_be), 32'(exp_be));
        check({nm, " we"}, 32'(data_we), 32'(op_we));
        if (op_we) check({nm, " wdata"}, data_wdata, exp_wd);
        tick();
      end
      gnt = 1'b0;
      check({nm, " req_dropped"}, 32'(data_req), 32'd0);
      check({nm, " no_early_valid"}, 32'(ovalid), 32'd0);
      rvalid   = 1'b1;
      rdata_in = mem_rdata;
      derr     = mem_err;
      tick();
      rvalid = 1'b0;
      derr   = 1'b0;
      check({nm, " o_valid"}, 32'(ovalid), 32'd1);
      tick();
      check({nm, " busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    valid    = 1'b0;
    we       = 1'b0;
    size     = 2'b00;
    uns      = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    gnt      = 1'b0;
    rvalid   = 1'b0;
    rdata_in = 32'h0;
    derr     = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset req", 32'(data_req), 32'd0);
    check("reset o_valid", 32'(ovalid), 32'd0);
    check("reset addr", data_addr, 32'h0);
    check("reset be", 32'(data_be), 32'd0);
    check("reset rdata", ordata, 32'h0);
    rst = 1'b0;
    tick();

    do_op("LW", 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 0, 32'hDEAD_BEEF, 1'b0,
          4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_op("LB", 1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 0, 32'h8012_3456, 1'b0,
          4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
    do_op("LBU", 1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 0, 32'h8012_3456, 1'b0,
          4'b1000, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
    do_op("LH", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 1, 32'h8012_3456, 1'b0,
          4'b1100, 32'h0, 32'hFFFF_8012, 1'b0, 1'b0);
    do_op("LHU", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 0, 32'h8012_3456, 1'b0,
          4'b1100, 32'h0, 32'h0000_8012, 1'b0, 1'b0);
    do_op("SH", 1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 3, 32'h1111_1111, 1'b0,
          4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b0);
    do_op("SB", 1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00A5, 0, 32'h2222_2222, 1'b0,
          4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
    do_op("LW_buserr", 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 0, 32'h1234_5678, 1'b1,
          4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
    do_op("LW_mis", 1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0, 0, 32'h0, 1'b0,
          4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_op("SZ11_mis", 1'b1, 2'b11, 1'b0, 32'h0000_7000, 32'h5555_5555, 0, 32'h0, 1'b0,
          4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_op("LW_timeout", 1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0, -1, 32'h0, 1'b0,
          4'hF, 32'h0, 32'h0, 1'b0, 1'b1);

    // Reset while waiting for rvalid; the late response must be ignored.
    valid = 1'b1;
    we    = 1'b0;
    size  = 2'b10;
    addr  = 32'h0000_4000;
    tick();
    valid = 1'b0;
    gnt   = 1'b1;
    tick();
    gnt = 1'b0;
    check("rst_wait in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    rvalid   = 1'b1;
    rdata_in = 32'hCAFE_F00D;
    check("rst_wait req", 32'(data_req), 32'd0);
    tick();
    rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_wait o_valid", 32'(ovalid), 32'd0);
      check("rst_wait busy", 32'(busy), 32'd0);
      check("rst_wait rdata", ordata, 32'h0);
      check("rst_wait addr", data_addr, 32'h0);
      check("rst_wait errs", 32'({err_mis, err_bus}), 32'd0);
      tick();
    end

    tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
